// File: rtl/cpc_mem_responder.sv
// CPC memory responder: folds CPU byte accesses and video word fetches onto one
// single-outstanding req/ack word-wide backing-store port, CPU first, ROM writes dropped.
module cpc_mem_responder #(
    parameter int unsigned          ADDR_W   = 23,
    parameter logic [ADDR_W-1:0]    ROM_BASE = 23'h400000
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    output logic [7:0]        cpu_rdata_o,
    input  logic              vid_req_i,
    input  logic [14:0]       vid_addr_i,
    output logic [15:0]       vid_rdata_o,
    output logic              vid_overrun_o,
    output logic              sd_req_o,
    output logic              sd_we_o,
    output logic [ADDR_W-2:0] sd_addr_o,
    output logic [1:0]        sd_be_o,
    output logic [15:0]       sd_wdata_o,
    input  logic              sd_ack_i,
    input  logic [15:0]       sd_rdata_i
);

    localparam int unsigned SdW = ADDR_W - 1;

    typedef enum logic [1:0] {StIdle, StCpuAcc, StVidAcc} state_e;

    state_e            state_q;
    logic              cpu_act_q;
    logic              cpu_pend_q;
    logic              cpu_we_q;
    logic [ADDR_W-1:0] cpu_addr_q;
    logic [7:0]        cpu_wdata_q;
    logic              cpu_lo_q;
    logic              vid_pend_q;
    logic [14:0]       vid_addr_q;
    logic              vid_overrun_q;
    logic [7:0]        cpu_rdata_q;
    logic [15:0]       vid_rdata_q;
    logic              sd_req_q;
    logic              sd_we_q;
    logic [SdW-1:0]    sd_addr_q;
    logic [1:0]        sd_be_q;
    logic [15:0]       sd_wdata_q;

    logic cpu_act;
    logic cpu_edge;
    logic rom_wr;

    assign cpu_act  = cpu_rd_i | cpu_wr_i;
    assign cpu_edge = cpu_act & ~cpu_act_q;
    assign rom_wr   = cpu_we_q && (cpu_addr_q >= ROM_BASE);

    // The slot is emptied when its access is issued, so an edge arriving while the
    // backend is busy waits in the slot instead of being cleared by the ack.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StIdle;
            cpu_act_q     <= 1'b0;
            cpu_pend_q    <= 1'b0;
            cpu_we_q      <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_wdata_q   <= '0;
            cpu_lo_q      <= 1'b0;
            vid_pend_q    <= 1'b0;
            vid_addr_q    <= '0;
            vid_overrun_q <= 1'b0;
            cpu_rdata_q   <= 8'hFF;
            vid_rdata_q   <= '0;
            sd_req_q      <= 1'b0;
            sd_we_q       <= 1'b0;
            sd_addr_q     <= '0;
            sd_be_q       <= '0;
            sd_wdata_q    <= '0;
        end else begin
            cpu_act_q <= cpu_act;
            case (state_q)
                StIdle: begin
                    if (cpu_pend_q) begin
                        cpu_pend_q <= 1'b0;
                        if (!rom_wr) begin
                            state_q    <= StCpuAcc;
                            sd_req_q   <= 1'b1;
                            sd_we_q    <= cpu_we_q;
                            sd_addr_q  <= cpu_addr_q[ADDR_W-1:1];
                            sd_be_q    <= cpu_addr_q[0] ? 2'b10 : 2'b01;
                            sd_wdata_q <= {2{cpu_wdata_q}};
                            cpu_lo_q   <= cpu_addr_q[0];
                        end
                    end else if (vid_pend_q) begin
                        vid_pend_q <= 1'b0;
                        state_q    <= StVidAcc;
                        sd_req_q   <= 1'b1;
                        sd_we_q    <= 1'b0;
                        sd_addr_q  <= SdW'(vid_addr_q);
                        sd_be_q    <= 2'b11;
                    end
                end
                StCpuAcc: begin
                    if (sd_ack_i) begin
                        sd_req_q <= 1'b0;
                        state_q  <= StIdle;
                        if (!sd_we_q) begin
                            cpu_rdata_q <= cpu_lo_q ? sd_rdata_i[15:8] : sd_rdata_i[7:0];
                        end
                    end
                end
                StVidAcc: begin
                    if (sd_ack_i) begin
                        sd_req_q    <= 1'b0;
                        state_q     <= StIdle;
                        vid_rdata_q <= sd_rdata_i;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Captures come last so a new arrival wins over the issue-time clear.
            if (cpu_edge) begin
                cpu_pend_q  <= 1'b1;
                cpu_addr_q  <= cpu_addr_i;
                cpu_wdata_q <= cpu_wdata_i;
                cpu_we_q    <= cpu_wr_i;
            end
            if (vid_req_i) begin
                if (vid_pend_q) begin
                    vid_overrun_q <= 1'b1;
                end
                vid_pend_q <= 1'b1;
                vid_addr_q <= vid_addr_i;
            end
        end
    end

    assign cpu_rdata_o   = cpu_rdata_q;
    assign vid_rdata_o   = vid_rdata_q;
    assign vid_overrun_o = vid_overrun_q;
    assign sd_req_o      = sd_req_q;
    assign sd_we_o       = sd_we_q;
    assign sd_addr_o     = sd_addr_q;
    assign sd_be_o       = sd_be_q;
    assign sd_wdata_o    = sd_wdata_q;

endmodule
